// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the 7-segment scan controller.
//   SEG_BLANK_CODE : decoder code that turns every segment off.
//   scan_state_e   : scan FSM states (all digits dark / one digit lit).
//   digit_code()   : per-digit decoder code with force-blank and
//                    leading-zero suppression applied.
package seg_pkg;

   localparam logic [4:0] SEG_BLANK_CODE = 5'h10;

   typedef enum logic {
      SCAN_BLANK = 1'b0,
      SCAN_SHOW  = 1'b1
   } scan_state_e;

   // upper_clear: every more significant digit is zero or force-blanked.
   // is_lsd: this is digit 0, which always shows its value.
   function automatic logic [4:0] digit_code(input logic [3:0] nib,
                                             input logic       blank,
                                             input logic       upper_clear,
                                             input logic       lzs_en,
                                             input logic       is_lsd);
      logic suppress;
      suppress = lzs_en && !is_lsd && (nib == 4'h0) && upper_clear;
      if (blank || suppress) return SEG_BLANK_CODE;
      return {1'b0, nib};
   endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// seg_dwell_timer: loadable down-counter timing the length of each scan state.
//   clk, rst_n : clock, asynchronous active-low reset.
//   load_i     : (cycles - 2) for the current state, sampled on its first cycle.
//   single_i   : the current state lasts exactly one cycle.
//   first_o    : this is the first cycle of the current state.
//   done_o     : this is the last cycle of the current state.
// The count is 0 on the first cycle of every state; the reload happens on
// that first cycle, so a state of N cycles ends when the count reaches 0 again.
module seg_dwell_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] load_i,
   input  logic         single_i,
   output logic         first_o,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         first_q, first_d;

   assign first_o = first_q;
   assign done_o  = first_q ? single_i : (cnt_q == '0);

   always_comb begin
      cnt_d   = cnt_q;
      first_d = done_o;
      if (done_o) begin
         cnt_d = '0;
      end else if (first_q) begin
         cnt_d = load_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         first_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display sharing one registered hex decoder.
//   clk, rst_n  : clock, asynchronous active-low reset.
//   upd_valid   : whole-display update request.
//   upd_ready   : no update is pending; a new one can be accepted.
//   upd_data    : nibble i (bits 4i+3:4i) is the hex value of digit i.
//   upd_dp      : decimal point per digit, 1 = lit.
//   upd_blank   : force digit blank, 1 = blank.
//   num         : registered code to the shared decoder, 5'h10 = blank.
//   dig_n       : active-low digit enables.
//   dp_n        : active-low decimal point.
//   frame_tick  : one-cycle pulse on the last cycle of each scan frame.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS    = 8,
   parameter int DWELL_CYC = 50000,
   parameter int BLANK_CYC = 2,
   parameter int LZS       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [4*DIGITS-1:0]   upd_data,
   input  logic [DIGITS-1:0]     upd_dp,
   input  logic [DIGITS-1:0]     upd_blank,
   output logic [4:0]            num,
   output logic [DIGITS-1:0]     dig_n,
   output logic                  dp_n,
   output logic                  frame_tick
);

   // The decoder needs one BLANK cycle to register num and one more for its
   // own output register before a digit may be lit.
   if (BLANK_CYC < 2) begin : g_bad_blank
      $error("seg_scan_ctrl: BLANK_CYC must be >= 2");
   end
   if (DWELL_CYC < 1) begin : g_bad_dwell
      $error("seg_scan_ctrl: DWELL_CYC must be >= 1");
   end

   localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int TW   = $clog2(MAXC);
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYC - 2);
   localparam logic [TW-1:0] DWELL_LOAD = (DWELL_CYC >= 2) ? TW'(DWELL_CYC - 2) : '0;

   scan_state_e             state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4:0]              num_q;
   logic [4*DIGITS-1:0]     act_data_q, pnd_data_q;
   logic [DIGITS-1:0]       act_dp_q, pnd_dp_q;
   logic [DIGITS-1:0]       act_blank_q, pnd_blank_q;
   logic                    pnd_q;

   logic [TW-1:0]           tmr_load;
   logic                    tmr_single, tmr_first, tmr_done;
   logic [4:0]              sel_code;
   logic [3:0]              nib;
   logic                    upper;

   assign tmr_load   = (state_q == SCAN_SHOW) ? DWELL_LOAD : BLANK_LOAD;
   assign tmr_single = (state_q == SCAN_SHOW) && (DWELL_CYC == 1);

   seg_dwell_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (tmr_load),
      .single_i (tmr_single),
      .first_o  (tmr_first),
      .done_o   (tmr_done)
   );

   assign num       = num_q;
   assign upd_ready = ~pnd_q;

   // Walk from the most significant digit down, carrying whether everything
   // above the current digit is zero or force-blanked.
   always_comb begin
      sel_code = SEG_BLANK_CODE;
      upper    = 1'b1;
      nib      = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib = act_data_q[4*i +: 4];
         if (IW'(i) == idx_q) begin
            sel_code = digit_code(nib, act_blank_q[i], upper, LZS != 0, i == 0);
         end
         upper = upper && (act_blank_q[i] || (nib == 4'h0));
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      dig_n      = '1;
      dp_n       = 1'b1;
      frame_tick = 1'b0;
      case (state_q)
         SCAN_BLANK: begin
            if (tmr_done) state_d = SCAN_SHOW;
         end
         SCAN_SHOW: begin
            dig_n[idx_q] = 1'b0;
            dp_n         = ~act_dp_q[idx_q];
            if (tmr_done) begin
               state_d = SCAN_BLANK;
               if (idx_q == IW'(DIGITS - 1)) begin
                  idx_d      = '0;
                  frame_tick = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = SCAN_BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SCAN_BLANK;
         idx_q       <= '0;
         num_q       <= SEG_BLANK_CODE;
         act_data_q  <= '0;
         act_dp_q    <= '0;
         act_blank_q <= '1;
         pnd_data_q  <= '0;
         pnd_dp_q    <= '0;
         pnd_blank_q <= '1;
         pnd_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         // num changes only on the first BLANK cycle so the decoder output
         // has settled before the digit is lit and stays put while lit.
         if (state_q == SCAN_BLANK && tmr_first) num_q <= sel_code;
         // Frame boundary: swap in the pending update for a tear-free frame.
         if (frame_tick && pnd_q) begin
            act_data_q  <= pnd_data_q;
            act_dp_q    <= pnd_dp_q;
            act_blank_q <= pnd_blank_q;
            pnd_q       <= 1'b0;
         end
         // Acceptance needs pnd_q low, so it never collides with the swap.
         if (upd_valid && upd_ready) begin
            pnd_data_q  <= upd_data;
            pnd_dp_q    <= upd_dp;
            pnd_blank_q <= upd_blank;
            pnd_q       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with DIGITS=4,
// DWELL_CYC=8, BLANK_CYC=2. Two instances run in lockstep on the same
// inputs, one without and one with leading-zero suppression.
module tb_seg_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic        upd_valid;
   logic [15:0] upd_data;
   logic [3:0]  upd_dp;
   logic [3:0]  upd_blank;
   logic        upd_ready, upd_ready_lz;
   logic [4:0]  num, num_lz;
   logic [3:0]  dig_n, dig_n_lz;
   logic        dp_n, dp_n_lz;
   logic        frame_tick, frame_tick_lz;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_tick = 0;

   typedef struct {
      int         dig;
      logic [4:0] c0;
      logic [4:0] c1;
      logic       dpn;
   } exp_t;
   exp_t exp_q[$];

   seg_scan_ctrl #(.DIGITS(4), .DWELL_CYC(8), .BLANK_CYC(2), .LZS(0)) dut (
      .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_data(upd_data), .upd_dp(upd_dp), .upd_blank(upd_blank),
      .num(num), .dig_n(dig_n), .dp_n(dp_n), .frame_tick(frame_tick));

   seg_scan_ctrl #(.DIGITS(4), .DWELL_CYC(8), .BLANK_CYC(2), .LZS(1)) dut_lz (
      .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready_lz),
      .upd_data(upd_data), .upd_dp(upd_dp), .upd_blank(upd_blank),
      .num(num_lz), .dig_n(dig_n_lz), .dp_n(dp_n_lz), .frame_tick(frame_tick_lz));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decoder code for digit i straight from the display rules.
   function automatic logic [4:0] model_code(input logic [15:0] d, input logic [3:0] b,
                                             input bit lz, input int i);
      logic [3:0] n;
      bit         sup;
      n = d[4*i +: 4];
      if (b[i]) return 5'h10;
      sup = lz && (i != 0) && (n == 4'h0);
      for (int j = i + 1; j < 4; j++) begin
         if (d[4*j +: 4] != 4'h0 && !b[j]) sup = 0;
      end
      return sup ? 5'h10 : {1'b0, n};
   endfunction

   task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.dig = i;
         e.c0  = model_code(d, b, 0, i);
         e.c1  = model_code(d, b, 1, i);
         e.dpn = ~p[i];
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_tick(input string tag, input bit chk_period);
      bit seen;
      int n;
      seen = 0;
      n = 0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         if (frame_tick === 1'b1) seen = 1;
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
      check({tag, "_lz_tick"}, 32'(frame_tick_lz), 32'd1);
      if (chk_period) check({tag, "_period"}, cyc - last_tick, 32'd40);
      last_tick = cyc;
   endtask

   // Step past the tick so the last visit of the old frame has been scored,
   // then queue the expected visits of the frame now starting.
   task automatic settle(input bit do_push, input logic [15:0] d, input logic [3:0] p,
                         input logic [3:0] b);
      @(negedge clk);
      #1;
      check("frame_drained", exp_q.size(), 32'd0);
      check("tick_one_cycle", 32'(frame_tick), 32'd0);
      if (do_push) push_frame(d, p, b);
   endtask

   // Visit monitor: gap and dwell lengths, digit walk order, stability of
   // num/dp_n while lit, and scoreboard compare at the end of each visit.
   int         gap_len, lit_len, next_dig, vis_dig;
   bit         in_lit, stable, gap_ok;
   logic [4:0] v_num0, v_num1;
   logic       v_dpn0, v_dpn1;
   logic [3:0] v_pat, want_pat;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         gap_len  = 0;
         lit_len  = 0;
         in_lit   = 0;
         next_dig = 0;
         gap_ok   = 1;
      end else if (dig_n != 4'hF) begin
         if (!in_lit) begin
            want_pat = ~(4'b0001 << next_dig);
            check("gap_len", gap_len, 32'd2);
            check("gap_dark", 32'(gap_ok), 32'd1);
            check("digit_walk", 32'(dig_n), 32'(want_pat));
            in_lit  = 1;
            lit_len = 1;
            stable  = 1;
            v_pat   = dig_n;
            vis_dig = next_dig;
            v_num0  = num;
            v_num1  = num_lz;
            v_dpn0  = dp_n;
            v_dpn1  = dp_n_lz;
         end else begin
            lit_len++;
            if (dig_n !== v_pat || dig_n_lz !== v_pat || num !== v_num0 ||
                num_lz !== v_num1 || dp_n !== v_dpn0 || dp_n_lz !== v_dpn1) stable = 0;
         end
      end else begin
         if (in_lit) begin
            check("dwell_len", lit_len, 32'd8);
            check("lit_stable", 32'(stable), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("visit_digit", vis_dig, e.dig);
               check("num", 32'(v_num0), 32'(e.c0));
               check("num_lzs", 32'(v_num1), 32'(e.c1));
               check("dp_n", 32'(v_dpn0), 32'(e.dpn));
               check("dp_n_lzs", 32'(v_dpn1), 32'(e.dpn));
            end
            next_dig = (vis_dig + 1) % 4;
            in_lit   = 0;
            gap_len  = 1;
            gap_ok   = 1;
         end else begin
            gap_len++;
         end
         if (dp_n !== 1'b1 || dp_n_lz !== 1'b1 || dig_n_lz !== 4'hF) gap_ok = 0;
      end
   end

   initial begin
      bit found;
      rst_n     = 1'b0;
      upd_valid = 1'b0;
      upd_data  = '0;
      upd_dp    = '0;
      upd_blank = '0;
      repeat (3) @(negedge clk);
      check("rst_num", 32'(num), 32'h10);
      check("rst_num_lz", 32'(num_lz), 32'h10);
      check("rst_dig_n", 32'(dig_n), 32'hF);
      check("rst_dp_n", 32'(dp_n), 32'd1);
      check("rst_ready", 32'(upd_ready), 32'd1);
      check("rst_ready_lz", 32'(upd_ready_lz), 32'd1);
      check("rst_tick", 32'(frame_tick), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle scan: every digit blank, 40-cycle frames.
      wait_tick("t0", 0);
      settle(1, 16'h0000, 4'b0000, 4'b1111);
      wait_tick("t1", 1);
      settle(1, 16'h0000, 4'b0000, 4'b1111);

      // Mid-frame update, then a second request while it is pending.
      check("ready_idle", 32'(upd_ready), 32'd1);
      upd_valid = 1'b1;
      upd_data  = 16'h12AF;
      upd_dp    = 4'b0100;
      upd_blank = 4'b0000;
      @(negedge clk);
      check("ready_drop", 32'(upd_ready), 32'd0);
      upd_data  = 16'hFFFF;
      upd_dp    = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ready_held", 32'(upd_ready), 32'd0);
      end
      upd_valid = 1'b0;
      wait_tick("t2", 1);
      check("ready_at_boundary", 32'(upd_ready), 32'd0);
      settle(1, 16'h12AF, 4'b0100, 4'b0000);
      check("ready_return", 32'(upd_ready), 32'd1);
      wait_tick("t3", 1);
      settle(1, 16'h12AF, 4'b0100, 4'b0000);

      // Leading zeros.
      @(negedge clk);
      upd_valid = 1'b1;
      upd_data  = 16'h0030;
      upd_dp    = 4'b0000;
      upd_blank = 4'b0000;
      @(negedge clk);
      upd_valid = 1'b0;
      wait_tick("t4", 0);
      settle(1, 16'h0030, 4'b0000, 4'b0000);

      // Leading zeros behind a force-blanked top digit; dp on a suppressed digit.
      @(negedge clk);
      upd_valid = 1'b1;
      upd_data  = 16'h7005;
      upd_dp    = 4'b0010;
      upd_blank = 4'b1000;
      @(negedge clk);
      upd_valid = 1'b0;
      wait_tick("t5", 0);
      settle(1, 16'h7005, 4'b0010, 4'b1000);

      // Update accepted on the frame_tick cycle waits for the next boundary.
      wait_tick("t6", 0);
      check("ready_on_tick", 32'(upd_ready), 32'd1);
      upd_valid = 1'b1;
      upd_data  = 16'h4321;
      upd_dp    = 4'b1001;
      upd_blank = 4'b0000;
      settle(1, 16'h7005, 4'b0010, 4'b1000);
      upd_valid = 1'b0;
      check("accept_on_tick", 32'(upd_ready), 32'd0);
      wait_tick("t7", 0);
      settle(1, 16'h4321, 4'b1001, 4'b0000);
      wait_tick("t8", 0);
      settle(0, 16'h0000, 4'b0000, 4'b0000);

      // Pending update, then asynchronous reset during SHOW of digit 2.
      @(negedge clk);
      upd_valid = 1'b1;
      upd_data  = 16'h9999;
      upd_dp    = 4'b1111;
      @(negedge clk);
      upd_valid = 1'b0;
      check("ready_pending", 32'(upd_ready), 32'd0);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (dig_n == 4'b1011) found = 1;
      end
      check("reach_digit2", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_dig_n", 32'(dig_n), 32'hF);
      check("arst_dig_n_lz", 32'(dig_n_lz), 32'hF);
      check("arst_num", 32'(num), 32'h10);
      check("arst_num_lz", 32'(num_lz), 32'h10);
      check("arst_dp_n", 32'(dp_n), 32'd1);
      check("arst_ready", 32'(upd_ready), 32'd1);
      check("arst_ready_lz", 32'(upd_ready_lz), 32'd1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("restart_blank0", 32'(dig_n), 32'hF);
      @(negedge clk);
      check("restart_blank1", 32'(dig_n), 32'hF);
      @(negedge clk);
      check("restart_digit0", 32'(dig_n), 32'hE);
      check("restart_num", 32'(num), 32'h10);
      wait_tick("t9", 0);
      settle(1, 16'h0000, 4'b0000, 4'b1111);
      wait_tick("t10", 1);
      settle(0, 16'h0000, 4'b0000, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
